// File: rtl/alu_pipe_hazard_param_if.sv
// Handshake bundle for alu_pipe_hazard_param: instruction in, result out.
// master = sequencer/consumer side, slave = the ALU pipe.
interface alu_pipe_hazard_param_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [AW-1:0]     in_src_a;
  logic [AW-1:0]     in_src_b;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;
  logic [AW-1:0]     in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [AW-1:0]     out_dest;
  logic [15:0]       stall_cnt;

  modport master (
    output in_valid, in_op, in_src_a, in_src_b,
    output in_use_imm, in_imm, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_dest,
    input  stall_cnt
  );

  modport slave (
    input  in_valid, in_op, in_src_a, in_src_b,
    input  in_use_imm, in_imm, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_dest,
    output stall_cnt
  );
endinterface

// File: rtl/alu_pipe_hazard_param.sv
// Three-stage ALU pipe with register file, RAW bypass or stall, and
// valid/ready on both ends. Ports: clk, rst_n (async low), io (slave).
module alu_pipe_hazard_param #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int FWD_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_pipe_hazard_param_if.slave  io
);
  localparam int AW = $clog2(REG_N);
  localparam int SW = $clog2(DATA_W);

  typedef struct packed {
    logic              v;
    logic [2:0]        op;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } s1_t;

  typedef struct packed {
    logic              v;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] res;
  } sr_t;

  s1_t               s1;
  sr_t               s2;
  sr_t               s3;
  logic [DATA_W-1:0] rf [REG_N];
  logic [15:0]       stall_q;

  function automatic logic [DATA_W-1:0] alu(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    unique case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[SW-1:0];
      3'd6: r = a >> b[SW-1:0];
      3'd7: r = {{(DATA_W-1){1'b0}},
                 ($signed(a) < $signed(b))};
    endcase
    return r;
  endfunction

  function automatic logic match(
    input logic          v,
    input logic [AW-1:0] d,
    input logic [AW-1:0] src
  );
    return v && (d == src) && (src != '0);
  endfunction

  logic [DATA_W-1:0] s1_res;
  logic a1, a2, a3, b1, b2, b3;
  logic hazard, adv, fire, stall_ev;
  logic [DATA_W-1:0] opa, opb, rd_a, rd_b;

  assign s1_res = alu(s1.op, s1.a, s1.b);

  assign a1 = match(s1.v, s1.dest, io.in_src_a);
  assign a2 = match(s2.v, s2.dest, io.in_src_a);
  assign a3 = match(s3.v, s3.dest, io.in_src_a);
  assign b1 = match(s1.v, s1.dest, io.in_src_b);
  assign b2 = match(s2.v, s2.dest, io.in_src_b);
  assign b3 = match(s3.v, s3.dest, io.in_src_b);

  assign hazard = a1 | a2 | a3 |
                  (!io.in_use_imm & (b1 | b2 | b3));

  assign adv = !(s3.v && !io.out_ready);

  assign io.in_ready = adv &&
                       !((FWD_EN == 0) && hazard);

  assign fire = io.in_valid && io.in_ready;

  assign stall_ev = io.in_valid && adv && hazard &&
                    (FWD_EN == 0);

  assign rd_a = (io.in_src_a == '0) ? '0
              : rf[io.in_src_a];
  assign rd_b = (io.in_src_b == '0) ? '0
              : rf[io.in_src_b];

  // Youngest producer wins: S1's ALU output is
  // what S2 will hold after this edge.
  always_comb begin
    opa = rd_a;
    if (FWD_EN != 0) begin
      if (a1)      opa = s1_res;
      else if (a2) opa = s2.res;
      else if (a3) opa = s3.res;
    end
  end

  always_comb begin
    opb = rd_b;
    if (io.in_use_imm) begin
      opb = io.in_imm;
    end else if (FWD_EN != 0) begin
      if (b1)      opb = s1_res;
      else if (b2) opb = s2.res;
      else if (b3) opb = s3.res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      stall_q <= '0;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      if (adv) begin
        s1.v <= fire;
        if (fire) begin
          s1.op   <= io.in_op;
          s1.dest <= io.in_dest;
          s1.a    <= opa;
          s1.b    <= opb;
        end
        s2.v    <= s1.v;
        s2.dest <= s1.dest;
        s2.res  <= s1_res;
        s3      <= s2;
      end
      if (s3.v && io.out_ready && s3.dest != '0)
        rf[s3.dest] <= s3.res;
      if (stall_ev && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign io.out_valid = s3.v;
  assign io.out_data  = s3.res;
  assign io.out_dest  = s3.dest;
  assign io.stall_cnt = stall_q;
endmodule

// File: tb/tb_alu_pipe_hazard_param.sv
// Directed bench: one bypassing and one stalling instance of the ALU pipe.
// Expected values are hand-computed constants.
module tb_alu_pipe_hazard_param;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct {
    int          op;
    int          a;
    int          b;
    int          ui;
    logic [31:0] imm;
    int          d;
    logic [31:0] expv;
  } vec_t;

  vec_t vq[$];

  alu_pipe_hazard_param_if #(.DATA_W(32), .AW(5)) f_if ();
  alu_pipe_hazard_param_if #(.DATA_W(32), .AW(5)) s_if ();

  alu_pipe_hazard_param #(
    .DATA_W(32), .REG_N(32), .FWD_EN(1)
  ) u_fwd (
    .clk(clk), .rst_n(rst_n), .io(f_if)
  );

  alu_pipe_hazard_param #(
    .DATA_W(32), .REG_N(32), .FWD_EN(0)
  ) u_stl (
    .clk(clk), .rst_n(rst_n), .io(s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] g_valid(int s);
    return (s != 0) ? 32'(f_if.out_valid)
                    : 32'(s_if.out_valid);
  endfunction

  function automatic logic [31:0] g_data(int s);
    return (s != 0) ? f_if.out_data : s_if.out_data;
  endfunction

  function automatic logic [31:0] g_dest(int s);
    return (s != 0) ? 32'(f_if.out_dest)
                    : 32'(s_if.out_dest);
  endfunction

  function automatic logic [31:0] g_ready(int s);
    return (s != 0) ? 32'(f_if.in_ready)
                    : 32'(s_if.in_ready);
  endfunction

  function automatic logic [31:0] g_stall(int s);
    return (s != 0) ? 32'(f_if.stall_cnt)
                    : 32'(s_if.stall_cnt);
  endfunction

  task automatic drive(int s, int v, int op, int a, int b,
                       int ui, logic [31:0] imm, int d);
    if (s != 0) begin
      f_if.in_valid   = 1'(v);
      f_if.in_op      = 3'(op);
      f_if.in_src_a   = 5'(a);
      f_if.in_src_b   = 5'(b);
      f_if.in_use_imm = 1'(ui);
      f_if.in_imm     = imm;
      f_if.in_dest    = 5'(d);
    end else begin
      s_if.in_valid   = 1'(v);
      s_if.in_op      = 3'(op);
      s_if.in_src_a   = 5'(a);
      s_if.in_src_b   = 5'(b);
      s_if.in_use_imm = 1'(ui);
      s_if.in_imm     = imm;
      s_if.in_dest    = 5'(d);
    end
  endtask

  task automatic idle(int s);
    drive(s, 0, 0, 0, 0, 0, 32'd0, 0);
  endtask

  task automatic pushv(int op, int a, int b, int ui,
                       logic [31:0] imm, int d,
                       logic [31:0] e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ui = ui;
    v.imm = imm; v.d = d; v.expv = e;
    vq.push_back(v);
  endtask

  // Issue queued vectors back-to-back; each must be
  // accepted at once and appear three samples later.
  task automatic run_seq(int s, string tag);
    int n;
    n = vq.size();
    for (int j = 0; j < n + 3; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        chk({tag, "_v"}, g_valid(s), 32'd1);
        chk({tag, "_d"}, g_data(s), vq[j-3].expv);
        chk({tag, "_dst"}, g_dest(s), 32'(vq[j-3].d));
      end
      if (j < n)
        drive(s, 1, vq[j].op, vq[j].a, vq[j].b,
              vq[j].ui, vq[j].imm, vq[j].d);
      else
        idle(s);
      #1;
      if (j < n) chk({tag, "_rdy"}, g_ready(s), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_end"}, g_valid(s), 32'd0);
    vq.delete();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle(1);
    idle(0);
    f_if.out_ready = 1'b1;
    s_if.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ov", g_valid(1), 32'd0);
    chk("rst_od", g_data(1), 32'd0);
    chk("rst_dst", g_dest(1), 32'd0);
    chk("rst_stl", g_stall(0), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy_f", g_ready(1), 32'd1);
    chk("rst_rdy_s", g_ready(0), 32'd1);

    // forwarding: 5, 7, 2 back-to-back
    pushv(0, 0, 0, 1, 32'd5, 1, 32'd5);
    pushv(0, 0, 0, 1, 32'd7, 2, 32'd7);
    pushv(1, 2, 1, 0, 32'd0, 3, 32'd2);
    run_seq(1, "fwd");
    chk("fwd_stl", g_stall(1), 32'd0);

    // ALU corners through the bypass path
    pushv(0, 0, 0, 1, 32'd1, 10, 32'd1);
    pushv(5, 10, 0, 1, 32'd31, 11, 32'h8000_0000);
    pushv(6, 11, 0, 1, 32'd31, 12, 32'd1);
    pushv(1, 0, 10, 0, 32'd0, 13, 32'hFFFF_FFFF);
    pushv(7, 13, 10, 0, 32'd0, 14, 32'd1);
    pushv(7, 10, 13, 0, 32'd0, 19, 32'd0);
    pushv(0, 0, 0, 1, 32'hF0, 15, 32'hF0);
    pushv(4, 15, 0, 1, 32'hFF, 16, 32'h0F);
    pushv(2, 16, 0, 1, 32'h05, 17, 32'h05);
    pushv(3, 16, 0, 1, 32'h30, 18, 32'h3F);
    pushv(0, 3, 0, 1, 32'd0, 23, 32'd2);
    run_seq(1, "alu");

    // stall path on the FWD_EN=0 instance
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 1, 32'd5, 1);
    #1 chk("st_rdy0", g_ready(0), 32'd1);
    @(negedge clk);
    chk("st_ov1", g_valid(0), 32'd0);
    drive(0, 1, 0, 0, 0, 1, 32'd7, 2);
    #1 chk("st_rdy1", g_ready(0), 32'd1);
    @(negedge clk);
    drive(0, 1, 1, 2, 1, 0, 32'd0, 3);
    #1 chk("st_rdy2", g_ready(0), 32'd0);
    @(negedge clk);
    chk("st_o5", g_data(0), 32'd5);
    chk("st_o5d", g_dest(0), 32'd1);
    #1 chk("st_rdy3", g_ready(0), 32'd0);
    @(negedge clk);
    chk("st_o7", g_data(0), 32'd7);
    chk("st_o7d", g_dest(0), 32'd2);
    #1 chk("st_rdy4", g_ready(0), 32'd0);
    @(negedge clk);
    chk("st_bub", g_valid(0), 32'd0);
    #1 chk("st_rdy5", g_ready(0), 32'd1);
    chk("st_cnt", g_stall(0), 32'd3);
    @(negedge clk);
    idle(0);
    chk("st_ov6", g_valid(0), 32'd0);
    @(negedge clk);
    chk("st_ov7", g_valid(0), 32'd0);
    @(negedge clk);
    chk("st_sv", g_valid(0), 32'd1);
    chk("st_sd", g_data(0), 32'd2);
    chk("st_sdst", g_dest(0), 32'd3);
    @(negedge clk);
    chk("st_end", g_valid(0), 32'd0);

    // backpressure: fill, hold 4 cycles, release
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 1, 32'd1, 5);
    #1 chk("bp_rdyA", g_ready(0), 32'd1);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 1, 32'd2, 6);
    #1 chk("bp_rdyB", g_ready(0), 32'd1);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 1, 32'd3, 7);
    #1 chk("bp_rdyC", g_ready(0), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_if.out_ready = 1'b0;
      drive(0, 1, 0, 0, 0, 1, 32'd4, 8);
      chk("bp_hv", g_valid(0), 32'd1);
      chk("bp_hd", g_data(0), 32'd1);
      chk("bp_hdst", g_dest(0), 32'd5);
      #1 chk("bp_rdy", g_ready(0), 32'd0);
      chk("bp_cnt", g_stall(0), 32'd3);
    end
    @(negedge clk);
    s_if.out_ready = 1'b1;
    chk("bp_rd", g_data(0), 32'd1);
    #1 chk("bp_rdyD", g_ready(0), 32'd1);
    @(negedge clk);
    idle(0);
    chk("bp_o2", g_data(0), 32'd2);
    chk("bp_o2d", g_dest(0), 32'd6);
    @(negedge clk);
    chk("bp_o3", g_data(0), 32'd3);
    chk("bp_o3d", g_dest(0), 32'd7);
    @(negedge clk);
    chk("bp_o4", g_data(0), 32'd4);
    chk("bp_o4d", g_dest(0), 32'd8);
    @(negedge clk);
    chk("bp_end", g_valid(0), 32'd0);
    chk("bp_cnt2", g_stall(0), 32'd3);

    // register 0 as destination, then read back
    pushv(0, 0, 0, 1, 32'd9, 0, 32'd9);
    pushv(0, 0, 0, 1, 32'd1, 20, 32'd1);
    pushv(0, 3, 0, 1, 32'd0, 22, 32'd2);
    pushv(0, 8, 0, 1, 32'd0, 21, 32'd4);
    run_seq(0, "r0");
    chk("r0_cnt", g_stall(0), 32'd3);

    // reset with three instructions in flight
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 1, 32'd1, 1);
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 1, 32'd1, 2);
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 1, 32'd1, 3);
    @(negedge clk);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ov", g_valid(1), 32'd0);
    chk("mr_od", g_data(1), 32'd0);
    chk("mr_stl", g_stall(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_late", g_valid(1), 32'd0);
      chk("mr_rdy", g_ready(1), 32'd1);
    end
    pushv(0, 1, 0, 1, 32'd0, 24, 32'd0);
    pushv(0, 3, 0, 1, 32'd0, 25, 32'd0);
    run_seq(1, "mr_rf");
    pushv(0, 8, 0, 1, 32'd0, 26, 32'd0);
    run_seq(0, "mr_rfs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe_hazard_param.md
# alu_pipe_hazard_param

Parametrised three-stage pipelined ALU with an integrated register file, RAW hazard handling, and a valid/ready handshake on both input and output. Instructions name source and destination registers. Results are written back to the register file when the output consumer accepts them. It succeeds the fixed 32-bit, four-op, non-backpressured pipelined ALU: width, register count and forwarding mode are parameters, and the op set is widened to eight operations with an immediate operand. It sits between an instruction sequencer and a result consumer.

## Interface
- DATA_W, 32: datapath width, ≥8.
- REG_N, 32: register count, power of 2; AW = $clog2(REG_N).
- FWD_EN, 1: 1 = bypass from the pipeline; 0 = stall on RAW hazard.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted on an edge where in_valid && in_ready.
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT.
- in_src_a  in  AW  source A register id.
- in_src_b  in  AW  source B register id.
- in_use_imm  in  1  1 = operand B is in_imm instead of reg[in_src_b].
- in_imm  in  DATA_W  immediate operand.
- in_dest  in  AW  destination register id.
- out_valid  out  1  result present in S3.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  result.
- out_dest  out  AW  destination id of the result.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

## Operation
- Register file:
  - REG_N × DATA_W.
  - Combinational read.
  - Register 0 reads 0 always; writes to register 0 are discarded.
- S1 (operand latch): captures op, dest and resolved operand values on handshake; S1 valid is set.
- S2 (execute): S2 result <= ALU(S1 operands), plus valid/dest.
- S3 (result): S3 <= S2. out_valid/out_data/out_dest come directly from S3.
- Write-back: on an edge with out_valid && out_ready && out_dest != 0, reg[out_dest] <= out_data.
- Global advance: adv = !(S3 valid && !out_ready). When adv = 0, S1–S3 all hold.
- Hazard condition: a compared source (A always; B only when in_use_imm = 0) is nonzero and equals the dest of a valid S1, S2 or S3 entry.
- FWD_EN = 1:
  - No hazard stall.
  - Operand source priority: ALU output of S1 > S2 result > S3 result > register file.
- FWD_EN = 0:
  - A hazard forces in_ready = 0 for that cycle.
  - While adv = 1, a bubble (valid 0) enters S1.
- in_ready = adv && !(FWD_EN == 0 && hazard).
- stall_cnt increments each cycle where in_valid && adv && hazard && FWD_EN == 0. It saturates at 0xFFFF.
- ALU rules:
  - ADD/SUB wrap modulo 2^DATA_W.
  - Shift amount = B[$clog2(DATA_W)-1:0]; SRL is logical.
  - SLT is a signed compare; result is 1 or 0, zero-extended.

## Timing
- Reset (asynchronous, mid-operation included):
  - All stage valids cleared; in-flight instructions discarded.
  - out_valid = 0, out_data = 0, out_dest = 0, stall_cnt = 0, all registers = 0.
  - in_ready = 1 once the reset is released.
- Latency: instruction accepted at edge k → out_valid high from edge k+2 with the result.
- Throughput: one instruction per cycle with no hazard stall and out_ready = 1.
- Simultaneous events:
  - Write-back at edge e plus a dependent issue in the cycle before e: FWD_EN = 1 takes the value from S3; FWD_EN = 0 stalls that cycle.
  - Register file is updated after e.
- Dependence distance: with FWD_EN = 0 and out_ready = 1, a dependent instruction immediately after its producer stalls exactly 3 cycles. Every out_ready = 0 cycle with the producer in S3 adds one more stall cycle.
- Ordering: results are output in issue order. No loss or duplication under any in_valid/out_ready pattern.
- Output holds: out_data/out_dest stay stable while out_valid && !out_ready.

## Test plan
- Reset mid-stream: rst_n low with 3 instructions in flight → out_valid 0 next sample, regs read 0, no late results after release, in_ready 1.
- Forwarding, FWD_EN=1, out_ready=1: back-to-back ADD r1=r0+imm5, ADD r2=r0+imm7, SUB r3=r2-r1 → outputs 5, 7, 2 on consecutive cycles, in_ready always 1, stall_cnt 0.
- Stall path, FWD_EN=0, same sequence as the forwarding test: r2 is issued back-to-back after r1 (no stall, since it reads only r0); SUB r3=r2-r1 then stalls → in_ready low 3 cycles before SUB is accepted, SUB output 2, stall_cnt 3, r3 reads 2 afterward.
- Backpressure: pipe full, out_ready low 4 cycles → in_ready 0, out_data stable, stall_cnt unchanged; release → queued results emerge in order, none dropped or duplicated.
- ALU corners, DATA_W=32:
  - SLL 1 by imm 31 → 0x80000000.
  - SRL 0x80000000 by 31 → 1.
  - SUB 0-1 → 0xFFFFFFFF.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - XOR 0xF0 with 0xFF → 0x0F.
- Register 0 dest: ADD r0=r0+imm9 → out_data 9, out_dest 0; a following read of r0 gives 0 and causes no hazard stall with FWD_EN=0.
